// File: rtl/bram_fifo_pkg.sv
// Shared types and constants for the BRAM-backed FIFO controller.
package bram_fifo_pkg;

  // Integer ceiling log2; returns at least 1 so it can size a counter directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned x;
    res = 0;
    x   = (value > 0) ? value - 1 : 0;
    while (x > 0) begin
      x   = x >> 1;
      res = res + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

  // Output buffer depth that hides the one-cycle BRAM read latency.
  localparam int unsigned OB_DEPTH = 2;
  // Width of the output buffer occupancy count (0..OB_DEPTH).
  localparam int unsigned OB_CNT_W = clog2(OB_DEPTH + 1);

  // Output buffer occupancy; encoding equals the word count.
  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } ob_state_e;

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Upstream sink, downstream source and BRAM port bundle of the FIFO controller.
// master: the controller's view; slave: the surrounding logic's view.
interface bram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_wr_addr;
  logic [DATA_WIDTH-1:0] bram_wr_data;
  logic [ADDR_WIDTH-1:0] bram_rd_addr;
  logic [DATA_WIDTH-1:0] bram_rd_data;

  modport master (
    input  s_valid, s_data, m_ready, bram_rd_data,
    output s_ready, m_valid, m_data, bram_we, bram_wr_addr, bram_wr_data, bram_rd_addr
  );

  modport slave (
    output s_valid, s_data, m_ready, bram_rd_data,
    input  s_ready, m_valid, m_data, bram_we, bram_wr_addr, bram_wr_data, bram_rd_addr
  );
endinterface

// File: rtl/block_ram_dual_port.sv
// Simple dual-port block RAM: one write port, one read port with registered read data.
module block_ram_dual_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bram_fifo_out_buf.sv
// Two-entry register buffer at the FIFO output; absorbs landed BRAM reads and
// presents the head word. A land and a pop in the same cycle are both honoured.
module bram_fifo_out_buf
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  land,
  input  logic [DATA_WIDTH-1:0] land_data,
  input  logic                  pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [OB_CNT_W-1:0]   ob_cnt
);
  ob_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // Occupancy state and the two data slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OB_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next occupancy and slot contents from land/pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      OB_EMPTY: begin
        if (land) begin
          head_d  = land_data;
          state_d = OB_ONE;
        end
      end
      OB_ONE: begin
        unique case ({land, pop})
          2'b10: begin
            tail_d  = land_data;
            state_d = OB_TWO;
          end
          2'b01:   state_d = OB_EMPTY;
          2'b11:   head_d  = land_data;
          default: ;
        endcase
      end
      OB_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (land) begin
            tail_d = land_data;
          end else begin
            state_d = OB_ONE;
          end
        end
      end
      default: state_d = OB_EMPTY;
    endcase
  end

  assign m_valid = (state_q != OB_EMPTY);
  assign m_data  = head_q;
  assign ob_cnt  = OB_CNT_W'(state_q);

  // The issue rule upstream must never land into a full buffer without a pop.
  ob_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(land && !pop && (state_q == OB_TWO)));
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO flow control around a dual-port BRAM with one-cycle registered reads.
// Upstream valid/ready sink, downstream valid/ready source, 1 word/cycle each way.
// Capacity is 2**ADDR_WIDTH words in BRAM plus 2 in the output buffer.
// Optional: define BRAM_FIFO_LEVEL_EN to add a registered total-occupancy port 'level'.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_fifo_ctrl_if.master      bus
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);
  localparam int unsigned           DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [OB_CNT_W:0]     OB_LIMIT = (OB_CNT_W + 1)'(OB_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   bram_cnt_q, bram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  s_ready;
  logic                  m_valid;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [OB_CNT_W-1:0]   ob_cnt;
  logic [OB_CNT_W:0]     ob_after;

  // Pointers, BRAM word count and the read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bram_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bram_cnt_q <= bram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Handshakes, read issue decision and next-state for the pointers/count.
  always_comb begin
    // s_ready comes from registers only, so it never depends on m_ready.
    s_ready  = (bram_cnt_q != FULL_CNT);
    push     = bus.s_valid & s_ready;
    pop      = m_valid & bus.m_ready;
    // Buffer occupancy after this cycle's pop, counting the word still in flight.
    // pop implies ob_cnt >= 1, so this cannot underflow.
    ob_after = {1'b0, ob_cnt} + {{OB_CNT_W{1'b0}}, inflight_q} - {{OB_CNT_W{1'b0}}, pop};
    // Registered count: a word written this cycle is not readable until next cycle.
    issue    = (bram_cnt_q != '0) && (ob_after < OB_LIMIT);

    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
    bram_cnt_d = bram_cnt_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
    inflight_d = issue;
  end

  assign bus.s_ready      = s_ready;
  assign bus.m_valid      = m_valid;
  assign bus.bram_we      = push;
  assign bus.bram_wr_addr = wr_ptr_q;
  assign bus.bram_wr_data = bus.s_data;
  assign bus.bram_rd_addr = rd_ptr_q;

  // Read data lands in the buffer exactly one cycle after issue.
  bram_fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .land      (inflight_q),
    .land_data (bus.bram_rd_data),
    .pop       (pop),
    .m_valid   (m_valid),
    .m_data    (bus.m_data),
    .ob_cnt    (ob_cnt)
  );

`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR_WIDTH+1:0] level_q, level_d;

  // Total occupancy only moves on push/pop; internal transfers leave it unchanged.
  always_comb begin
    level_d = level_q + (ADDR_WIDTH + 2)'(push) - (ADDR_WIDTH + 2)'(pop);
  end

  // Registered occupancy: bram_cnt + inflight + ob_cnt as of the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with an attached 4-word BRAM.
// Accepted words go to a scoreboard queue; every downstream pop is compared.
module tb_bram_fifo_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic clk;
  logic rst_n;

  bram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  bram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    .level (level)
`endif
  );

  block_ram_dual_port #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_bram (
    .clk     (clk),
    .we      (bus.bram_we),
    .wr_addr (bus.bram_wr_addr),
    .wr_data (bus.bram_wr_data),
    .rd_addr (bus.bram_rd_addr),
    .rd_data (bus.bram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  logic        inv_bad  = 1'b0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard and occupancy invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        n_pop++;
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(bus.m_data), 32'hFFFF_FFFF);
        end else begin
          exp_word = sb_q.pop_front();
          check("out_data", 32'(bus.m_data), 32'(exp_word));
        end
      end
      if (bus.s_valid && bus.s_ready) sb_q.push_back(bus.s_data);
      if ((dut.ob_cnt > 2) || (dut.bram_cnt_q > 4)) inv_bad = 1'b1;
    end
  end

  task automatic drain(input string tag);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) step();
    step();
    step();
    sample();
    check({tag, "_drain_left"}, 32'(sb_q.size()), 0);
    check({tag, "_drain_mvalid"}, 32'(bus.m_valid), 0);
    step();
  endtask

  int          acc;
  int          gaps;
  int          pop_start;
  int          cyc;
  logic        seen_valid;
  logic        hs;
  logic [DW-1:0] data;

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    sample();
    check("rst_s_ready", 32'(bus.s_ready), 1);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data", 32'(bus.m_data), 0);
    check("rst_bram_we", 32'(bus.bram_we), 0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("rst_level", 32'(level), 0);
`endif

    // 1: single word. Accepted on the edge closing cycle P, issued in P+1,
    // landed on the edge closing P+2, visible from P+3.
    step();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    bus.m_ready = 1'b1;
    sample();
    check("t1_we", 32'(bus.bram_we), 1);
    check("t1_wr_addr", 32'(bus.bram_wr_addr), 0);
    check("t1_wr_data", 32'(bus.bram_wr_data), 32'hA5);
    step();
    bus.s_valid = 1'b0;
    sample();
    check("t1_mvalid_p1", 32'(bus.m_valid), 0);
    step();
    sample();
    check("t1_mvalid_p2", 32'(bus.m_valid), 0);
    step();
    sample();
    check("t1_mvalid_p3", 32'(bus.m_valid), 1);
    check("t1_mdata_p3", 32'(bus.m_data), 32'hA5);
    step();
    sample();
    check("t1_mvalid_p4", 32'(bus.m_valid), 0);
    step();

    // 2: fill with m_ready low; only 6 of 7 words fit.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    data        = 8'h01;
    bus.s_data  = data;
    acc         = 0;
    for (int i = 0; i < 14; i++) begin
      sample();
      hs = bus.s_valid && bus.s_ready;
      if (hs) acc++;
      step();
      if (hs) begin
        data++;
        bus.s_data = data;
      end
    end
    sample();
    check("t2_accepted", 32'(acc), 6);
    check("t2_full_ready", 32'(bus.s_ready), 0);
    step();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    acc         = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (bus.m_valid) acc++;
      step();
    end
    check("t2_gapless", 32'(acc), 6);
    sample();
    check("t2_empty_after", 32'(bus.m_valid), 0);
    check("t2_sb_empty", 32'(sb_q.size()), 0);
    step();

    // 3: streaming, 20 words, pointers wrap several times.
    pop_start   = n_pop;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    data        = 8'h40;
    bus.s_data  = data;
    acc         = 0;
    gaps        = 0;
    seen_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      hs = bus.s_valid && bus.s_ready;
      if (hs) acc++;
      if (bus.m_valid) seen_valid = 1'b1;
      else if (seen_valid) gaps++;
      step();
      if (hs) begin
        data++;
        bus.s_data = data;
      end
    end
    check("t3_accepted", 32'(acc), 20);
    check("t3_gaps", 32'(gaps), 0);
    drain("t3");
    check("t3_popped", 32'(n_pop - pop_start), 20);

    // 4: random valid and backpressure over 1000 words.
    pop_start   = n_pop;
    acc         = 0;
    cyc         = 0;
    bus.s_valid = 1'b0;
    hs          = 1'b0;
    while (acc < 1000 && cyc < 20000) begin
      if (!bus.s_valid || hs) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = 8'($urandom);
      end
      bus.m_ready = 1'($urandom_range(0, 1));
      sample();
      hs = bus.s_valid && bus.s_ready;
      if (hs) acc++;
      step();
      cyc++;
    end
    check("t4_accepted", 32'(acc), 1000);
    drain("t4");
    check("t4_popped", 32'(n_pop - pop_start), 1000);
    check("t4_invariant", 32'(inv_bad), 0);

    // 5: reset with three words stored.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    data        = 8'h90;
    bus.s_data  = data;
    acc         = 0;
    for (int i = 0; i < 20 && acc < 3; i++) begin
      sample();
      hs = bus.s_valid && bus.s_ready;
      if (hs) acc++;
      step();
      if (hs) begin
        data++;
        bus.s_data = data;
      end
    end
    bus.s_valid = 1'b0;
    step();
    step();
    sample();
    check("t5_pre_mvalid", 32'(bus.m_valid), 1);
    step();
    rst_n = 1'b0;
    #1;
    check("t5_rst_mvalid", 32'(bus.m_valid), 0);
    check("t5_rst_s_ready", 32'(bus.s_ready), 1);
    sb_q.delete();
    step();
    rst_n     = 1'b1;
    pop_start = n_pop;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3C;
    bus.m_ready = 1'b1;
    sample();
    check("t5_push_ok", 32'(bus.s_ready), 1);
    step();
    bus.s_valid = 1'b0;
    drain("t5");
    check("t5_popped", 32'(n_pop - pop_start), 1);

    // 6: completely full, one-cycle pop with s_valid held.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    data        = 8'hC0;
    bus.s_data  = data;
    for (int i = 0; i < 20; i++) begin
      sample();
      hs = bus.s_valid && bus.s_ready;
      step();
      if (hs) begin
        data++;
        bus.s_data = data;
      end
    end
    sample();
    check("t6_full", 32'(bus.s_ready), 0);
    check("t6_full_mvalid", 32'(bus.m_valid), 1);
`ifdef BRAM_FIFO_LEVEL_EN
    check("t6_level_full", 32'(level), 6);
`endif
    step();
    bus.m_ready = 1'b1;
    sample();
    check("t6_pulse_ready", 32'(bus.s_ready), 0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("t6_level_a", 32'(level), 6);
`endif
    step();
    bus.m_ready = 1'b0;
    sample();
    check("t6_ready_after_pop", 32'(bus.s_ready), 1);
`ifdef BRAM_FIFO_LEVEL_EN
    check("t6_level_b", 32'(level), 5);
`endif
    hs = bus.s_valid && bus.s_ready;
    step();
    if (hs) begin
      data++;
      bus.s_data = data;
    end
    sample();
    check("t6_refull", 32'(bus.s_ready), 0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("t6_level_c", 32'(level), 6);
`endif
    step();
    pop_start = n_pop;
    drain("t6");
    check("t6_popped", 32'(n_pop - pop_start), 6);
    check("final_invariant", 32'(inv_bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
